// File: rtl/scp_pkg.sv
// Shared definitions for the SCP control unit: opcodes, FSM states and the
// control-strobe bundle driven into the datapath.
package scp_pkg;

    localparam int unsigned WAIT_W = 3;
    localparam int unsigned TO_W   = 8;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_IN    = 3'b101;
    localparam logic [2:0] OP_OUT   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMRD,
        S_MEMWR,
        S_IOWAIT,
        S_EXEC,
        S_HALT
    } state_t;

    typedef struct packed {
        logic start;
        logic add_sub;
        logic shift;
        logic ac_sel;
        logic load_acc;
        logic rd;
        logic wr;
        logic io_mem_sel;
        logic in_ready;
        logic out_valid;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/scp_wait_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
module scp_wait_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/scp_controller.sv
// Multi-cycle control FSM for the 8-bit SCP datapath.
// Optional I/O handshake timeout enabled by defining SCP_CTRL_IO_TIMEOUT_EN.
module scp_controller
    import scp_pkg::*;
#(
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [2:0] opCode,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       start,
    output logic       AddSub,
    output logic       Shift,
    output logic       AcSel,
    output logic       LoadAcc,
    output logic       rd,
    output logic       wr,
    output logic       IOMemSel,
    output logic       in_ready,
    output logic       out_valid,
    output logic       halted,
    output logic       io_timeout
);

    localparam logic [WAIT_W-1:0] MEM_WAIT_V = WAIT_W'(MEM_WAIT);
    localparam int unsigned       TO_LOAD    = (TO_CYCLES > 0) ? (TO_CYCLES - 1) : 0;

    state_t            state;
    state_t            state_next;
    logic [2:0]        op_q;
    logic [2:0]        op_cur_c;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_next;
    logic              io_timeout_q;
    logic              timeout_set_c;
    logic              last_c;

    logic              wait_load_c;
    logic              wait_en_c;
    logic [WAIT_W-1:0] wait_count;
    logic              wait_done;
    logic              to_expired_c;

    // Opcode is read live while decoding, then held for the rest of the instruction.
    assign op_cur_c = (state == S_DECODE) ? opCode : op_q;

    assign wait_load_c = (state_next != state);
    assign wait_en_c   = (state == S_MEMRD) || (state == S_MEMWR);

    scp_wait_timer #(.W(WAIT_W)) u_mem_wait (
        .clk   (clk),
        .rst_n (reset),
        .load  (wait_load_c),
        .value (MEM_WAIT_V),
        .en    (wait_en_c),
        .count (wait_count),
        .done  (wait_done)
    );

`ifdef SCP_CTRL_IO_TIMEOUT_EN
    logic              to_load_c;
    logic              to_done;
    logic [TO_W-1:0]   to_count_unused;

    assign to_load_c = (state_next == S_IOWAIT) && (state != S_IOWAIT);

    scp_wait_timer #(.W(TO_W)) u_io_timeout (
        .clk   (clk),
        .rst_n (reset),
        .load  (to_load_c),
        .value (TO_W'(TO_LOAD)),
        .en    (state == S_IOWAIT),
        .count (to_count_unused),
        .done  (to_done)
    );

    assign to_expired_c = to_done;
`else
    assign to_expired_c = 1'b0;
`endif

    // State, held opcode and registered control strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            ctrl_q       <= '0;
            io_timeout_q <= 1'b0;
        end else begin
            state        <= state_next;
            op_q         <= op_cur_c;
            ctrl_q       <= ctrl_next;
            io_timeout_q <= io_timeout_q | timeout_set_c;
        end
    end

    // Next state plus Moore decode of the state being entered.
    always_comb begin
        state_next    = state;
        timeout_set_c = 1'b0;
        ctrl_next     = '0;
        last_c        = 1'b0;

        unique case (state)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                unique case (opCode)
                    OP_LOAD, OP_ADD, OP_SUB: state_next = S_MEMRD;
                    OP_STORE:                state_next = S_MEMWR;
                    OP_IN, OP_OUT:           state_next = S_IOWAIT;
                    OP_SHL:                  state_next = S_EXEC;
                    OP_HALT:                 state_next = S_HALT;
                    default:                 state_next = S_HALT;
                endcase
            end
            S_MEMRD, S_MEMWR: if (wait_done) state_next = S_FETCH;
            S_EXEC:   state_next = S_FETCH;
            S_IOWAIT: begin
                if (op_q == OP_IN) begin
                    if (in_valid && ctrl_q.in_ready) begin
                        state_next = S_MEMWR;
                    end else if (to_expired_c) begin
                        state_next    = S_FETCH;
                        timeout_set_c = 1'b1;
                    end
                end else begin
                    if (out_ready && ctrl_q.out_valid) begin
                        state_next = S_FETCH;
                    end else if (to_expired_c) begin
                        state_next    = S_FETCH;
                        timeout_set_c = 1'b1;
                    end
                end
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase

        // Final cycle of a memory access: fresh entry with no wait, or counter about to hit zero.
        if (state_next != state) begin
            last_c = (MEM_WAIT_V == '0);
        end else begin
            last_c = (wait_count == WAIT_W'(1));
        end

        unique case (state_next)
            S_FETCH:  ctrl_next.start = 1'b1;
            S_MEMRD: begin
                ctrl_next.rd = 1'b1;
                if (last_c) begin
                    ctrl_next.load_acc = 1'b1;
                    ctrl_next.ac_sel   = (op_cur_c != OP_LOAD);
                    ctrl_next.add_sub  = (op_cur_c == OP_SUB);
                end
            end
            S_MEMWR: begin
                ctrl_next.wr         = 1'b1;
                ctrl_next.io_mem_sel = (op_cur_c == OP_IN);
            end
            S_EXEC: begin
                ctrl_next.shift    = 1'b1;
                ctrl_next.ac_sel   = 1'b1;
                ctrl_next.load_acc = 1'b1;
            end
            S_IOWAIT: begin
                if (op_cur_c == OP_IN) begin
                    ctrl_next.in_ready   = 1'b1;
                    ctrl_next.io_mem_sel = 1'b1;
                end else begin
                    ctrl_next.out_valid = 1'b1;
                end
            end
            S_HALT:   ctrl_next.halted = 1'b1;
            default:  ctrl_next = '0;
        endcase
    end

    assign start      = ctrl_q.start;
    assign AddSub     = ctrl_q.add_sub;
    assign Shift      = ctrl_q.shift;
    assign AcSel      = ctrl_q.ac_sel;
    assign LoadAcc    = ctrl_q.load_acc;
    assign rd         = ctrl_q.rd;
    assign wr         = ctrl_q.wr;
    assign IOMemSel   = ctrl_q.io_mem_sel;
    assign in_ready   = ctrl_q.in_ready;
    assign out_valid  = ctrl_q.out_valid;
    assign halted     = ctrl_q.halted;
    assign io_timeout = io_timeout_q;

endmodule
